life_engine: RTL and testbench
==============================

LIFE_ENGINE -- requirements
Module: life_engine

Interface
REQ-001 Parameter ROWS, default 8, grid row count (>=3).
REQ-002 Parameter COLS, default 8, grid column count and row-word width (>=3).
REQ-003 Parameter GEN_W, default 16, generation-counter width.
REQ-004 Ports: clk  in  1  single clock, all state updates on rising edge.
REQ-005 Ports: reset  in  1  asynchronous, active-high reset.
REQ-006 Ports: load_valid  in  1  write load_data into row load_row.
REQ-007 Ports: load_row  in  $clog2(ROWS)  target row index for load.
REQ-008 Ports: load_data  in  COLS  row contents, bit c = column c, 1 = live.
REQ-009 Ports: step  in  1  request one generation.
REQ-010 Ports: rd_row  in  $clog2(ROWS)  display read index.
REQ-011 Ports: rd_data  out  COLS  committed contents of rd_row, combinational.
REQ-012 Ports: busy  out  1  high while a generation is in progress.
REQ-013 Ports: done  out  1  one-cycle pulse when a generation commits.
REQ-014 Ports: stable  out  1  registered, valid from done: new grid equals previous grid.
REQ-015 Ports: gen_count  out  GEN_W  generations committed since reset.

Function
REQ-016 States IDLE, COMPUTE, COMMIT; IDLE->COMPUTE on step; COMPUTE->COMMIT after row ROWS-1 computed; COMMIT->IDLE unconditionally.
REQ-017 COMPUTE evaluates one row per cycle, row 0 first, reading only the committed grid and writing a shadow grid.
REQ-018 Cell rule: next = (n==3) | (live & n==2), n = live count of 8 neighbours (4-bit).
REQ-019 COMMIT copies shadow to committed grid, pulses done, increments gen_count (wraps at 2^GEN_W-1 -> 0), updates stable.
REQ-020 Latency step->done = ROWS+1 cycles; busy high from cycle after step through the COMMIT cycle.
REQ-021 rd_data reflects only the committed grid; never shows partially computed generations.
REQ-022 load_valid honoured only in IDLE; ignored while busy.
REQ-023 step ignored while busy (no queuing).
REQ-024 load_valid and step together in IDLE: load written that edge, generation computes on the updated grid.
REQ-025 load_row or rd_row >= ROWS: load ignored, rd_data = 0.

Reset
REQ-026 reset clears committed and shadow grids, state=IDLE, busy=0, done=0, stable=0, gen_count=0.
REQ-027 reset mid-COMPUTE abandons the generation; no done pulse, gen_count unchanged at 0.

Configuration
REQ-028 Macro LIFE_WRAP_EN defined: toroidal neighbourhood, row/column indices wrap modulo ROWS/COLS.
REQ-029 LIFE_WRAP_EN undefined: cells outside the grid count as dead.

Structure
REQ-030 Package life_pkg holds state enum, default ROWS/COLS/GEN_W constants, neighbour-count width.
REQ-031 Sub-module life_cell_rule: combinational, inputs center and 8 neighbours, output next; instantiated COLS times for the active row.

Verification
REQ-032 Blinker: load row3=8'b00011100 others 0, step -> done at cycle 9, row2/3/4 = 8'b00001000, stable=0, gen_count=1.
REQ-033 Block still life: rows3,4=8'b00011000, step -> grid unchanged, stable=1.
REQ-034 Edge glider, LIFE_WRAP_EN defined, 4 steps x 8 -> glider reappears shifted (+1,+1) across wrap; undefined -> cells crossing edge die.
REQ-035 Load row0=8'hFF during busy -> grid unaffected, rd_data(0) retains prior value after done.
REQ-036 reset asserted at COMPUTE cycle 4 -> busy=0 immediately, all rd_data=0, no done pulse, gen_count=0.
REQ-037 gen_count with GEN_W=2: 4 steps -> values 1,2,3,0.

Source files
------------

// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared types and defaults for the life_engine generation stepper
package life_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_COMMIT  = 2'd2
    } life_state_e;

    localparam int DEF_ROWS  = 8;
    localparam int DEF_COLS  = 8;
    localparam int DEF_GEN_W = 16;
    localparam int NCNT_W    = 4;

endpackage

// File: rtl/life_cell_rule.sv
// rtl/life_cell_rule.sv - combinational next-state rule for one cell from its 8 neighbours
module life_cell_rule
    import life_pkg::*;
(
    input  logic       center_i,
    input  logic [7:0] nbr_i,
    output logic       next_o
);

    logic [NCNT_W-1:0] cnt;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {{(NCNT_W-1){1'b0}}, nbr_i[i]};
        end
    end

    assign next_o = (cnt == NCNT_W'(3)) || (center_i && (cnt == NCNT_W'(2)));

endmodule

// File: rtl/life_engine.sv
// rtl/life_engine.sv - row-serial Game of Life engine with shadow grid and atomic commit
// Optional LIFE_WRAP_EN selects a toroidal neighbourhood instead of dead borders.
module life_engine
    import life_pkg::*;
#(
    parameter int ROWS  = DEF_ROWS,
    parameter int COLS  = DEF_COLS,
    parameter int GEN_W = DEF_GEN_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_valid,
    input  logic [$clog2(ROWS)-1:0] load_row,
    input  logic [COLS-1:0]         load_data,
    input  logic                    step,
    input  logic [$clog2(ROWS)-1:0] rd_row,
    output logic [COLS-1:0]         rd_data,
    output logic                    busy,
    output logic                    done,
    output logic                    stable,
    output logic [GEN_W-1:0]        gen_count
);

    localparam int RW = $clog2(ROWS);

    life_state_e                state_q;
    logic [RW-1:0]              row_q;
    logic [ROWS-1:0][COLS-1:0]  grid_q;
    logic [ROWS-1:0][COLS-1:0]  shadow_q;
    logic                       busy_q;
    logic                       done_q;
    logic                       stable_q;
    logic [GEN_W-1:0]           gen_q;

    logic [COLS-1:0]            row_up, row_mid, row_dn;
    logic [COLS+1:0]            up_ext, mid_ext, dn_ext;
    logic [COLS-1:0]            next_row_d;

    // Neighbour rows come only from the committed grid; bit 0 of each *_ext is column -1.
    always_comb begin
        row_mid = grid_q[row_q];
`ifdef LIFE_WRAP_EN
        row_up  = grid_q[(row_q == '0) ? RW'(ROWS-1) : row_q - 1'b1];
        row_dn  = grid_q[(row_q == RW'(ROWS-1)) ? '0 : row_q + 1'b1];
        up_ext  = {row_up[0],  row_up,  row_up[COLS-1]};
        mid_ext = {row_mid[0], row_mid, row_mid[COLS-1]};
        dn_ext  = {row_dn[0],  row_dn,  row_dn[COLS-1]};
`else
        row_up  = (row_q == '0) ? '0 : grid_q[row_q - 1'b1];
        row_dn  = (row_q == RW'(ROWS-1)) ? '0 : grid_q[row_q + 1'b1];
        up_ext  = {1'b0, row_up,  1'b0};
        mid_ext = {1'b0, row_mid, 1'b0};
        dn_ext  = {1'b0, row_dn,  1'b0};
`endif
    end

    for (genvar c = 0; c < COLS; c++) begin : g_cell
        life_cell_rule u_rule (
            .center_i (mid_ext[c+1]),
            .nbr_i    ({up_ext[c+2], up_ext[c+1], up_ext[c],
                        mid_ext[c+2], mid_ext[c],
                        dn_ext[c+2], dn_ext[c+1], dn_ext[c]}),
            .next_o   (next_row_d[c])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            row_q    <= '0;
            grid_q   <= '0;
            shadow_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            stable_q <= 1'b0;
            gen_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load_valid && (32'(load_row) < ROWS)) begin
                        grid_q[load_row] <= load_data;
                    end
                    if (step) begin
                        state_q <= ST_COMPUTE;
                        row_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_COMPUTE: begin
                    shadow_q[row_q] <= next_row_d;
                    if (row_q == RW'(ROWS-1)) begin
                        state_q <= ST_COMMIT;
                    end else begin
                        row_q <= row_q + 1'b1;
                    end
                end
                ST_COMMIT: begin
                    grid_q   <= shadow_q;
                    stable_q <= (shadow_q == grid_q);
                    done_q   <= 1'b1;
                    gen_q    <= gen_q + 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_data   = (32'(rd_row) < ROWS) ? grid_q[rd_row] : '0;
    assign busy      = busy_q;
    assign done      = done_q;
    assign stable    = stable_q;
    assign gen_count = gen_q;

endmodule

// File: tb/tb_life_engine.sv
// tb/tb_life_engine.sv - randomized scoreboard bench for life_engine against a cell-rule reference model
module tb_life_engine;

    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int GEN_W = 3;
    localparam int RW    = $clog2(ROWS);

    typedef logic [ROWS-1:0][COLS-1:0] grid_t;
    typedef struct {
        grid_t            g;
        bit               st;
        logic [GEN_W-1:0] gen;
        int               cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              load_valid = 1'b0;
    logic [RW-1:0]     load_row = '0;
    logic [COLS-1:0]   load_data = '0;
    logic              step = 1'b0;
    logic [RW-1:0]     rd_row = '0;
    logic [COLS-1:0]   rd_data;
    logic              busy, done, stable;
    logic [GEN_W-1:0]  gen_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int idle_from = 0;
    exp_t q[$];
    grid_t model = '0;
    grid_t cmt = '0;
    logic [GEN_W-1:0] gen_m = '0;

    life_engine #(.ROWS(ROWS), .COLS(COLS), .GEN_W(GEN_W)) dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_row(load_row),
        .load_data(load_data), .step(step), .rd_row(rd_row), .rd_data(rd_data),
        .busy(busy), .done(done), .stable(stable), .gen_count(gen_count)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference: count live neighbours of every cell directly from the rules.
    function automatic grid_t life_next(input grid_t g);
        grid_t n;
        int cnt, rr, cc;
        n = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr != 0 || dc != 0) begin
                            rr = r + dr;
                            cc = c + dc;
`ifdef LIFE_WRAP_EN
                            rr = (rr + ROWS) % ROWS;
                            cc = (cc + COLS) % COLS;
                            cnt += int'(g[rr][cc]);
`else
                            if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS) cnt += int'(g[rr][cc]);
`endif
                        end
                    end
                end
                n[r][c] = (cnt == 3) || (g[r][c] && cnt == 2);
            end
        end
        return n;
    endfunction

    task automatic apply(input bit lv, input int lrow, input logic [COLS-1:0] ld, input bit st);
        int e;
        exp_t x;
        e = cyc;
        load_valid = lv;
        load_row   = lrow[RW-1:0];
        load_data  = ld;
        step       = st;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        step = 1'b0;
        if (e >= idle_from) begin
            if (lv) begin
                model[lrow] = ld;
                cmt[lrow] = ld;
            end
            if (st) begin
                x.g   = life_next(model);
                x.st  = (x.g == model);
                gen_m = gen_m + 1'b1;
                x.gen = gen_m;
                x.cyc = e + ROWS + 2;
                q.push_back(x);
                model = x.g;
                idle_from = e + ROWS + 2;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(1'b0, 0, '0, 1'b0);
    endtask

    task automatic clear_grid();
        for (int r = 0; r < ROWS; r++) apply(1'b1, r, '0, 1'b0);
    endtask

    // Monitor: pops one expectation per done pulse; otherwise checks one committed row per cycle.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (reset) begin
                q.delete();
                cmt = '0;
                chk("rst_done", done, 0);
                for (int r = 0; r < ROWS; r++) begin
                    rd_row = RW'(r);
                    #1;
                    chk("rst_row_zero", rd_data, 0);
                end
            end else if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", done, 0);
                end else begin
                    x = q.pop_front();
                    chk("done_cycle", cyc, x.cyc);
                    chk("gen_count", gen_count, x.gen);
                    chk("stable", stable, x.st);
                    chk("busy_at_done", busy, 0);
                    cmt = x.g;
                    for (int r = 0; r < ROWS; r++) begin
                        rd_row = RW'(r);
                        #1;
                        chk("grid_row", rd_data, x.g[r]);
                    end
                end
            end else begin
                rd_row = RW'(cyc % ROWS);
                #1;
                chk("committed_row", rd_data, cmt[cyc % ROWS]);
            end
        end
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_stable", stable, 0);
        chk("rst_gen", gen_count, 0);
        reset = 1'b0;
        idle(2);

        // Blinker
        apply(1'b1, 3, 8'b0001_1100, 1'b0);
        apply(1'b0, 0, '0, 1'b1);
        chk("busy_after_step", busy, 1);
        idle(ROWS + 2);
        chk("blinker_gen", gen_count, 1);
        chk("blinker_stable", stable, 0);

        // Block still life
        clear_grid();
        apply(1'b1, 3, 8'b0001_1000, 1'b0);
        apply(1'b1, 4, 8'b0001_1000, 1'b1);
        idle(ROWS + 2);
        chk("block_stable", stable, 1);

        // Load and step while busy are ignored
        apply(1'b0, 0, '0, 1'b1);
        apply(1'b1, 0, 8'hFF, 1'b0);
        apply(1'b1, 0, 8'hFF, 1'b1);
        idle(3);
        apply(1'b1, 0, 8'hFF, 1'b1);
        idle(ROWS);

        // Glider walking into the bottom-right corner
        clear_grid();
        apply(1'b1, 5, 8'b0100_0000, 1'b0);
        apply(1'b1, 6, 8'b1000_0000, 1'b0);
        apply(1'b1, 7, 8'b1110_0000, 1'b0);
        for (int s = 0; s < 4 * ROWS; s++) begin
            apply(1'b0, 0, '0, 1'b1);
            idle(ROWS + 1);
        end

        // Random loads and steps, including overlaps with busy
        for (int i = 0; i < 400; i++) begin
            apply(($urandom % 4) == 0, $urandom_range(0, ROWS-1), COLS'($urandom), ($urandom % 6) == 0);
        end
        idle(ROWS + 2);

        // Reset in the middle of a computation
        apply(1'b0, 0, '0, 1'b1);
        idle(4);
        reset = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_gen", gen_count, 0);
        model = '0;
        cmt = '0;
        gen_m = '0;
        idle_from = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(ROWS + 4);
        chk("post_rst_gen", gen_count, 0);

        // Counter wrap on the narrow gen_count after a fresh reset
        apply(1'b1, 2, 8'b0011_1000, 1'b0);
        for (int s = 0; s < 9; s++) begin
            apply(1'b0, 0, '0, 1'b1);
            idle(ROWS + 1);
        end
        chk("gen_wrap", gen_count, 1);

        for (int i = 0; i < 50 && q.size() != 0; i++) idle(1);
        if (q.size() != 0) chk("scoreboard_drain", q.size(), 0);
        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
